pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the in-order RV32I core; successor to the fixed 6-bit stall controller.
- Merges per-stage stall requests, a pipeline flush request and an internal multi-cycle-op countdown.
- Drives per-stage stall (hold) and bubble (insert NOP) vectors, plus a saturating stall-cycle performance counter.
- Stage index 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB. A lower index holds a younger instruction.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/mc_countdown.sv | 60 ++++++
 rtl/pipe_hazard_ctrl.sv | 85 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared stage indices and multi-cycle FSM encoding for the hazard controller
package pipe_pkg;
   localparam int ST_PC  = 0;
   localparam int ST_IF  = 1;
   localparam int ST_ID  = 2;
   localparam int ST_EX  = 3;
   localparam int ST_MEM = 4;
   localparam int ST_WB  = 5;

   localparam int STAGES_DEF = 6;

   typedef enum logic {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_t;
endpackage

// File: rtl/mc_countdown.sv
// rtl/mc_countdown.sv - multi-cycle op countdown: holds its stage until the last cycle of the op
module mc_countdown
   import pipe_pkg::*;
#(
   parameter int LEN_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mc_start,
   input  logic [LEN_W-1:0] mc_len,
   input  logic             abort,
   output logic             mc_busy,
   output logic             mc_done,
   output logic             mc_stall
);

   mc_state_t        state;
   logic [LEN_W-1:0] cnt;
   logic             start_long;
   logic             last;

   assign start_long = mc_start && (mc_len >= LEN_W'(2));
   assign last       = (state == MC_BUSY) && (cnt == LEN_W'(1));

   // mc_stall must not depend on abort: abort is derived from the stall level
   assign mc_stall = ((state == MC_IDLE) && start_long) ||
                     ((state == MC_BUSY) && (cnt != LEN_W'(1)));
   assign mc_done  = rst_n && !abort &&
                     (((state == MC_IDLE) && mc_start && !start_long) || last);
   assign mc_busy  = (state == MC_BUSY);

   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         state <= MC_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            MC_IDLE: begin
               if (start_long) begin
                  cnt   <= mc_len - LEN_W'(1);
                  state <= MC_BUSY;
               end
            end
            MC_BUSY: begin
               if (last) begin
                  cnt   <= '0;
                  state <= MC_IDLE;
               end else begin
                  cnt <= cnt - LEN_W'(1);
               end
            end
            default: begin
               cnt   <= '0;
               state <= MC_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - merges stall/flush/multi-cycle requests into per-stage stall and bubble vectors
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int STAGES   = STAGES_DEF,
   parameter int MC_STAGE = ST_EX,
   parameter int LEN_W    = 6,
   parameter int CNT_W    = 32,
   localparam int FW      = $clog2(STAGES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [STAGES-1:0] stallreq,
   input  logic              flush_req,
   input  logic [FW-1:0]     flush_src,
   input  logic              mc_start,
   input  logic [LEN_W-1:0]  mc_len,
   input  logic              perf_clr,
   output logic [STAGES-1:0] stall,
   output logic [STAGES-1:0] bubble,
   output logic              flush_taken,
   output logic              mc_busy,
   output logic              mc_done,
   output logic [CNT_W-1:0]  stall_cycles
);

   logic              mc_stall;
   logic              abort;
   logic              flush_ok;
   logic [STAGES-1:0] req;
   int                lvl;

   mc_countdown #(.LEN_W(LEN_W)) u_mc (
      .clk      (clk),
      .rst_n    (rst_n),
      .mc_start (mc_start),
      .mc_len   (mc_len),
      .abort    (abort),
      .mc_busy  (mc_busy),
      .mc_done  (mc_done),
      .mc_stall (mc_stall)
   );

   // lvl = -1 means no stage requests a stall
   always_comb begin
      req           = stallreq;
      req[MC_STAGE] = stallreq[MC_STAGE] | mc_stall;
      lvl           = -1;
      for (int i = 0; i < STAGES; i++) begin
         if (req[i]) lvl = i;
      end
   end

   // An older stall freezes the flushing stage, so the flush waits until L<=F
   assign flush_ok    = rst_n && flush_req && (lvl <= int'(flush_src));
   assign flush_taken = flush_ok;
   assign abort       = flush_ok && (int'(flush_src) > MC_STAGE);

   always_comb begin
      stall  = '0;
      bubble = '0;
      if (!rst_n) begin
         stall  = '0;
         bubble = '0;
      end else if (flush_ok) begin
         for (int i = 1; i < STAGES; i++) begin
            if (i <= int'(flush_src)) bubble[i] = 1'b1;
         end
      end else if (lvl >= 0) begin
         for (int i = 0; i < STAGES; i++) begin
            if (i <= lvl)     stall[i]  = 1'b1;
            if (i == lvl + 1) bubble[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || perf_clr) begin
         stall_cycles <= '0;
      end else if (stall[0] && !(&stall_cycles)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with a behavioural model
module tb_pipe_hazard_ctrl;
   localparam int STAGES = 6;
   localparam int MCS    = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  stallreq;
   logic        flush_req;
   logic [2:0]  flush_src;
   logic        mc_start;
   logic [5:0]  mc_len;
   logic        perf_clr;
   logic [5:0]  stall, bubble, stall_b, bubble_b;
   logic        flush_taken, mc_busy, mc_done, flush_taken_b, mc_busy_b, mc_done_b;
   logic [31:0] stall_cycles;
   logic [3:0]  stall_cycles_b;

   typedef struct packed {
      logic [5:0]  stall;
      logic [5:0]  bubble;
      logic        ft;
      logic        done;
      logic        busy;
      logic        chk_reg;
      logic [31:0] sc;
      logic [3:0]  sc4;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   int   m_rem = 0;
   int   m_sc  = 0;
   int   m_sc4 = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n), .stallreq(stallreq), .flush_req(flush_req),
      .flush_src(flush_src), .mc_start(mc_start), .mc_len(mc_len), .perf_clr(perf_clr),
      .stall(stall), .bubble(bubble), .flush_taken(flush_taken), .mc_busy(mc_busy),
      .mc_done(mc_done), .stall_cycles(stall_cycles)
   );

   pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .stallreq(stallreq), .flush_req(flush_req),
      .flush_src(flush_src), .mc_start(mc_start), .mc_len(mc_len), .perf_clr(perf_clr),
      .stall(stall_b), .bubble(bubble_b), .flush_taken(flush_taken_b), .mc_busy(mc_busy_b),
      .mc_done(mc_done_b), .stall_cycles(stall_cycles_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // One clock of stimulus; the model works in "cycles left in the op" rather than a counter
   task automatic drive(input logic rst, input logic [5:0] sr, input logic fr, input logic [2:0] fs,
                        input logic ms, input logic [5:0] ml, input logic pc);
      exp_t e;
      int   cur, lv;
      logic [5:0] rq;
      logic fl, ab;
      @(posedge clk);
      #1;
      rst_n = rst; stallreq = sr; flush_req = fr; flush_src = fs;
      mc_start = ms; mc_len = ml; perf_clr = pc;
      e = '0;
      e.busy = (m_rem > 0);
      e.sc = m_sc;
      e.sc4 = m_sc4[3:0];
      e.chk_reg = rst;
      if (!rst) begin
         m_rem = 0; m_sc = 0; m_sc4 = 0;
      end else begin
         if (m_rem == 0) cur = ms ? ((ml == 0) ? 1 : int'(ml)) : 0;
         else            cur = m_rem;
         rq = sr;
         if (cur >= 2) rq[MCS] = 1'b1;
         lv = -1;
         for (int i = 0; i < STAGES; i++) if (rq[i]) lv = i;
         fl = fr && (lv <= int'(fs));
         e.ft = fl;
         if (fl) begin
            for (int i = 1; i < STAGES; i++) if (i <= int'(fs)) e.bubble[i] = 1'b1;
         end else begin
            for (int i = 0; i < STAGES; i++) begin
               if (i <= lv) e.stall[i] = 1'b1;
               if (lv >= 0 && i == lv + 1) e.bubble[i] = 1'b1;
            end
         end
         ab = fl && (int'(fs) > MCS);
         e.done = (cur == 1) && !ab;
         m_rem = ab ? 0 : ((cur > 1) ? cur - 1 : 0);
         if (pc) begin
            m_sc = 0; m_sc4 = 0;
         end else if (e.stall[0]) begin
            m_sc++;
            if (m_sc4 < 15) m_sc4++;
         end
      end
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 6'b0, 1'b0, 3'd0, 1'b0, 6'd0, 1'b0);
   endtask

   // Monitor: the DUT presents a response every cycle; compare mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall",       32'(stall),       32'(e.stall));
            chk("bubble",      32'(bubble),      32'(e.bubble));
            chk("flush_taken", 32'(flush_taken), 32'(e.ft));
            chk("mc_done",     32'(mc_done),     32'(e.done));
            if (e.chk_reg) begin
               chk("mc_busy",      32'(mc_busy),        32'(e.busy));
               chk("stall_cycles", stall_cycles,        e.sc);
               chk("stall_sat4",   32'(stall_cycles_b), 32'(e.sc4));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; stallreq = '0; flush_req = 1'b0; flush_src = '0;
      mc_start = 1'b0; mc_len = '0; perf_clr = 1'b0;
      drive(1'b0, 6'b0, 1'b0, 3'd0, 1'b0, 6'd0, 1'b0);
      drive(1'b0, 6'b0, 1'b0, 3'd0, 1'b0, 6'd0, 1'b0);
      idle(1);
      // single requests
      drive(1'b1, 6'b000100, 1'b0, 3'd0, 1'b0, 6'd0, 1'b0);
      drive(1'b1, 6'b001000, 1'b0, 3'd0, 1'b0, 6'd0, 1'b0);
      // multi-cycle op, len 3 then len 1
      drive(1'b1, 6'b0, 1'b0, 3'd0, 1'b1, 6'd3, 1'b0);
      idle(3);
      drive(1'b1, 6'b0, 1'b0, 3'd0, 1'b1, 6'd1, 1'b0);
      // flush taken / frozen
      drive(1'b1, 6'b000100, 1'b1, 3'd3, 1'b0, 6'd0, 1'b0);
      drive(1'b1, 6'b010000, 1'b1, 3'd3, 1'b0, 6'd0, 1'b0);
      // abort of a long op
      drive(1'b1, 6'b0, 1'b0, 3'd0, 1'b1, 6'd10, 1'b0);
      idle(2);
      drive(1'b1, 6'b0, 1'b1, 3'd4, 1'b0, 6'd0, 1'b0);
      idle(12);
      // counter: clear, saturate the 4-bit copy, then clear while stalling
      drive(1'b1, 6'b0, 1'b0, 3'd0, 1'b0, 6'd0, 1'b1);
      for (int i = 0; i < 20; i++) drive(1'b1, 6'b000001, 1'b0, 3'd0, 1'b0, 6'd0, 1'b0);
      idle(1);
      drive(1'b1, 6'b000010, 1'b0, 3'd0, 1'b0, 6'd0, 1'b1);
      idle(1);
      // reset mid-BUSY with requests active
      drive(1'b1, 6'b0, 1'b0, 3'd0, 1'b1, 6'd10, 1'b0);
      idle(2);
      drive(1'b0, 6'b111111, 1'b1, 3'd2, 1'b0, 6'd0, 1'b0);
      idle(2);
      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [5:0] sr;
         logic       ms;
         for (int b = 0; b < 6; b++) sr[b] = ($urandom_range(0, 5) == 0);
         ms = (m_rem == 0) && ($urandom_range(0, 5) == 0);
         drive(($urandom_range(0, 80) != 0), sr, ($urandom_range(0, 4) == 0),
               3'($urandom_range(0, 7)), ms, 6'($urandom_range(0, 12)),
               ($urandom_range(0, 40) == 0));
      end
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
